// File: rtl/lab7_pkg.sv
// Shared bus encodings, address map and widths for the lab7bonus data bus.
package lab7_pkg;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MREAD  = 2'b01,
    MWRITE = 2'b10
  } mem_cmd_e;

  localparam logic [ADDR_W-1:0] LED_ADDR = 9'h100;
  localparam logic [ADDR_W-1:0] SW_ADDR  = 9'h140;
  localparam logic [ADDR_W-1:0] KEY_ADDR = 9'h141;

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a per-bit stability counter; also flags debounced 1->0 edges.
module sync_debounce #(
  parameter int unsigned WIDTH           = 1,
  parameter bit          RESET_VAL       = 1'b0,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] db_o,
  output logic [WIDTH-1:0] fall_o
);

  logic [WIDTH-1:0]       meta_q, sync_q;
  logic [WIDTH-1:0]       db_q, db_d;
  logic [WIDTH-1:0][15:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= {WIDTH{RESET_VAL}};
      sync_q <= {WIDTH{RESET_VAL}};
      db_q   <= {WIDTH{RESET_VAL}};
      cnt_q  <= '0;
    end else begin
      meta_q <= raw_i;
      sync_q <= meta_q;
      db_q   <= db_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DEBOUNCE_CYCLES - 16'd1) begin
        db_d[i]  = sync_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
  end

  assign db_o   = db_q;
  // Asserted during the cycle whose closing edge drops the debounced bit.
  assign fall_o = db_q & ~db_d;

endmodule

// File: rtl/mmio_responder.sv
// Bus target above RAM: LED register, debounced switch port and clear-on-read key events.
module mmio_responder #(
  parameter logic [15:0]                   DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [lab7_pkg::ADDR_W-1:0]   LED_ADDR        = lab7_pkg::LED_ADDR,
  parameter logic [lab7_pkg::ADDR_W-1:0]   SW_ADDR         = lab7_pkg::SW_ADDR,
  parameter logic [lab7_pkg::ADDR_W-1:0]   KEY_ADDR        = lab7_pkg::KEY_ADDR
) (
  input  logic                          CLOCK_50,
  input  logic                          rst_n,
  input  logic [1:0]                    mem_cmd,
  input  logic [lab7_pkg::ADDR_W-1:0]   mem_addr,
  input  logic [lab7_pkg::DATA_W-1:0]   write_data,
  output logic [lab7_pkg::DATA_W-1:0]   read_data,
  output logic                          hit,
  input  logic                          halt,
  input  logic [7:0]                    sw_in,
  input  logic [1:0]                    key_in_n,
  output logic [9:0]                    ledr
);
  import lab7_pkg::*;

  logic [7:0] led_q, led_d;
  logic       halt_q;
  logic [1:0] key_ev_q, key_ev_d;
  logic [7:0] sw_db;
  logic [1:0] key_fall;
  logic       rd_sw, rd_key, wr_led;
  logic [7:0] unused_sw_fall;
  logic [1:0] unused_key_db;
  logic [7:0] unused_wdata_hi;

  assign unused_wdata_hi = write_data[15:8];

  sync_debounce #(
    .WIDTH          (8),
    .RESET_VAL      (1'b0),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sw_db (
    .clk_i (CLOCK_50),
    .rst_ni(rst_n),
    .raw_i (sw_in),
    .db_o  (sw_db),
    .fall_o(unused_sw_fall)
  );

  sync_debounce #(
    .WIDTH          (2),
    .RESET_VAL      (1'b1),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_db (
    .clk_i (CLOCK_50),
    .rst_ni(rst_n),
    .raw_i (key_in_n),
    .db_o  (unused_key_db),
    .fall_o(key_fall)
  );

  assign rd_sw  = (mem_cmd == MREAD)  && (mem_addr == SW_ADDR);
  assign rd_key = (mem_cmd == MREAD)  && (mem_addr == KEY_ADDR);
  assign wr_led = (mem_cmd == MWRITE) && (mem_addr == LED_ADDR);

  always_comb begin
    led_d    = wr_led ? write_data[7:0] : led_q;
    // A press landing on the clearing edge survives.
    key_ev_d = (key_ev_q & ~{2{rd_key}}) | key_fall;
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      led_q    <= '0;
      halt_q   <= 1'b0;
      key_ev_q <= '0;
    end else begin
      led_q    <= led_d;
      halt_q   <= halt_q | halt;
      key_ev_q <= key_ev_d;
    end
  end

  always_comb begin
    read_data = '0;
    if (rd_sw) begin
      read_data = {8'h00, sw_db};
    end else if (rd_key) begin
      read_data = {14'h0, key_ev_q};
    end
  end

  assign hit  = rd_sw | rd_key;
  assign ledr = {1'b0, halt_q, led_q};

endmodule

// File: tb/tb_mmio_responder.sv
// Scoreboard bench: stimulus queues expected bus/LED values, a negedge monitor pops and compares.
module tb_mmio_responder;
  import lab7_pkg::*;

  typedef struct {
    logic [15:0] rd;
    logic        hit;
    logic [9:0]  led;
    string       nm;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        hit;
  logic        halt;
  logic [7:0]  sw_in;
  logic [1:0]  key_in_n;
  logic [9:0]  ledr;
  logic        obs = 1'b0;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mmio_responder #(
    .DEBOUNCE_CYCLES(16'd4)
  ) dut (
    .CLOCK_50  (clk),
    .rst_n     (rst_n),
    .mem_cmd   (mem_cmd),
    .mem_addr  (mem_addr),
    .write_data(write_data),
    .read_data (read_data),
    .hit       (hit),
    .halt      (halt),
    .sw_in     (sw_in),
    .key_in_n  (key_in_n),
    .ledr      (ledr)
  );

  // Monitor: compares whatever the DUT presents in each observed cycle.
  always @(negedge clk) begin
    if (obs) begin
      exp_t e;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL no_expectation: rd=%h hit=%b ledr=%h with empty scoreboard",
                 read_data, hit, ledr);
      end else begin
        e = q.pop_front();
        if (read_data !== e.rd || hit !== e.hit || ledr !== e.led) begin
          bad++;
          $display("FAIL %s: got rd=%h hit=%b ledr=%h, want rd=%h hit=%b ledr=%h",
                   e.nm, read_data, hit, ledr, e.rd, e.hit, e.led);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one bus cycle, queue its expected outputs, then advance past the edge.
  task automatic op(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] wd,
                    input logic [15:0] exp_rd, input logic exp_hit, input logic [9:0] exp_led,
                    input string nm);
    exp_t e;
    mem_cmd    = cmd;
    mem_addr   = addr;
    write_data = wd;
    e.rd  = exp_rd;
    e.hit = exp_hit;
    e.led = exp_led;
    e.nm  = nm;
    q.push_back(e);
    obs = 1'b1;
    tick();
    obs      = 1'b0;
    mem_cmd  = MNONE;
  endtask

  initial begin
    rst_n      = 1'b0;
    mem_cmd    = MNONE;
    mem_addr   = '0;
    write_data = '0;
    halt       = 1'b0;
    sw_in      = 8'h00;
    key_in_n   = 2'b11;
    tick();
    op(MNONE, 9'h000, 16'h0, 16'h0000, 1'b0, 10'h000, "reset_state");
    op(MREAD, KEY_ADDR, 16'h0, 16'h0000, 1'b1, 10'h000, "reset_key_read");
    rst_n = 1'b1;

    // LED register path and ignored commands
    op(MWRITE, LED_ADDR, 16'hABCD, 16'h0000, 1'b0, 10'h000, "wr_led_cycle");
    op(MNONE, 9'h000, 16'h0, 16'h0000, 1'b0, 10'h0CD, "led_after_wr");
    op(MWRITE, 9'h101, 16'h1234, 16'h0000, 1'b0, 10'h0CD, "wr_other");
    op(MNONE, 9'h000, 16'h0, 16'h0000, 1'b0, 10'h0CD, "wr_other_ignored");
    op(2'b11, LED_ADDR, 16'h00FF, 16'h0000, 1'b0, 10'h0CD, "cmd11");
    op(MNONE, 9'bx, 16'h0, 16'h0000, 1'b0, 10'h0CD, "cmd11_no_effect");
    op(MREAD, LED_ADDR, 16'h0, 16'h0000, 1'b0, 10'h0CD, "rd_led_nohit");

    // Asynchronous reset mid-cycle: observed before any further edge
    rst_n = 1'b0;
    op(MNONE, 9'h000, 16'h0, 16'h0000, 1'b0, 10'h000, "async_rst");
    rst_n = 1'b1;

    // Switch debounce latency: 2 sync + 4 debounce edges
    sw_in = 8'h5A;
    repeat (5) tick();
    op(MREAD, SW_ADDR, 16'h0, 16'h0000, 1'b1, 10'h000, "sw_edge5");
    op(MREAD, SW_ADDR, 16'h0, 16'h005A, 1'b1, 10'h000, "sw_edge6");

    // 3-cycle glitch on bit 0 never reaches the debounced value
    sw_in = 8'h5B;
    for (int i = 0; i < 3; i++) op(MREAD, SW_ADDR, 16'h0, 16'h005A, 1'b1, 10'h000, "sw_glitch_in");
    sw_in = 8'h5A;
    for (int i = 0; i < 8; i++) op(MREAD, SW_ADDR, 16'h0, 16'h005A, 1'b1, 10'h000, "sw_glitch_out");

    // Key 1 press, then clear-on-read
    key_in_n = 2'b01;
    repeat (7) tick();
    op(MREAD, KEY_ADDR, 16'h0, 16'h0002, 1'b1, 10'h000, "key1_event");
    op(MREAD, KEY_ADDR, 16'h0, 16'h0000, 1'b1, 10'h000, "key1_cleared");

    // Key 0 press lands on the clearing edge: set beats clear
    key_in_n = 2'b00;
    repeat (5) tick();
    op(MREAD, KEY_ADDR, 16'h0, 16'h0000, 1'b1, 10'h000, "key0_same_edge_old");
    op(MREAD, KEY_ADDR, 16'h0, 16'h0001, 1'b1, 10'h000, "key0_survives");
    op(MREAD, KEY_ADDR, 16'h0, 16'h0000, 1'b1, 10'h000, "key0_cleared");

    // Releases are rising edges and must not raise events
    key_in_n = 2'b11;
    repeat (8) tick();
    op(MREAD, KEY_ADDR, 16'h0, 16'h0000, 1'b1, 10'h000, "release_no_event");

    // Halt is sticky on ledr[8]
    halt = 1'b1;
    op(MNONE, 9'h000, 16'h0, 16'h0000, 1'b0, 10'h000, "halt_pre_edge");
    halt = 1'b0;
    op(MNONE, 9'h000, 16'h0, 16'h0000, 1'b0, 10'h100, "halt_set");
    op(MWRITE, LED_ADDR, 16'h0033, 16'h0000, 1'b0, 10'h100, "halt_hold");
    op(MREAD, 9'h1FF, 16'h0, 16'h0000, 1'b0, 10'h133, "rd_unmapped");
    op(MREAD, SW_ADDR, 16'h0, 16'h005A, 1'b1, 10'h133, "sw_still");
    rst_n = 1'b0;
    op(MNONE, 9'h000, 16'h0, 16'h0000, 1'b0, 10'h000, "halt_rst");
    op(MREAD, SW_ADDR, 16'h0, 16'h0000, 1'b1, 10'h000, "sw_rst");
    rst_n = 1'b1;

    tick();
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
